a2d_chnl_sequencer: RTL and testbench

//  Sits directly upstream of A2D_intf. Drives strt_cnv/chnnl to scan ADC channels 0..NUM_CHNL-1

---
 rtl/a2d_chnl_sequencer.sv | 129 ++++++++++++
 tb/tb_a2d_chnl_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_chnl_sequencer.sv
// Round-robin ADC channel sequencer feeding A2D_intf, with a per-channel result bank.
// Optional build macro A2D_AVG_EN: average 4 back-to-back samples per channel before storing.
module a2d_chnl_sequencer #(
  parameter int NUM_CHNL = 8,
  parameter int SETTLE   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [2:0]  rd_chnl,
  output logic [11:0] rd_data,
  output logic        sweep_done
);

  // state | meaning
  // IDLE  | stopped, channel pointer parked at 0
  // START | one-cycle strt_cnv for chnnl
  // WAIT  | conversion in flight, waiting for cnv_cmplt
  // GAP   | settle delay before the next START

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  localparam logic [2:0] LAST_CHNL  = 3'(NUM_CHNL - 1);
  localparam logic [3:0] GAP_LOAD   = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [3:0] NUM_CHNL_W = 4'(NUM_CHNL);

  state_t      state, nxt_state;
  logic [2:0]  cur, cur_inc, nxt_cur;
  logic [3:0]  gap_cnt;
  logic [11:0] bank [0:7];
  logic        cmplt_w;
  logic        last_smp;
  logic [11:0] wr_val;

  assign cmplt_w = (state == WAIT) && cnv_cmplt;
  assign cur_inc = (cur == LAST_CHNL) ? 3'd0 : cur + 3'd1;

`ifdef A2D_AVG_EN
  logic [1:0]  smp_cnt;
  logic [13:0] acc, acc_sum;

  assign acc_sum  = acc + {2'b00, res};
  assign last_smp = (smp_cnt == 2'd3);
  assign wr_val   = acc_sum[13:2];

  // Partial sums are dropped whenever the sequencer parks in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt <= 2'd0;
      acc     <= 14'd0;
    end else if (nxt_state == IDLE) begin
      smp_cnt <= 2'd0;
      acc     <= 14'd0;
    end else if (cmplt_w) begin
      smp_cnt <= smp_cnt + 2'd1;
      acc     <= last_smp ? 14'd0 : acc_sum;
    end
  end
`else
  assign last_smp = 1'b1;
  assign wr_val   = res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:  if (en) nxt_state = START;
      START: nxt_state = WAIT;
      WAIT: begin
        if (cnv_cmplt) begin
          if (!en)              nxt_state = IDLE;
          else if (SETTLE == 0) nxt_state = START;
          else                  nxt_state = GAP;
        end
      end
      GAP: begin
        if (!en)                nxt_state = IDLE;
        else if (gap_cnt == 4'd0) nxt_state = START;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    strt_cnv = (state == START);
    rd_data  = 12'h000;
    if ({1'b0, rd_chnl} < NUM_CHNL_W) rd_data = bank[rd_chnl];
  end

  // cur advances when a channel is finished, so chnnl can be loaded from nxt_cur on entry to START.
  always_comb begin
    nxt_cur = cur;
    if (nxt_state == IDLE)         nxt_cur = 3'd0;
    else if (cmplt_w && last_smp)  nxt_cur = cur_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= 3'd0;
      chnnl      <= 3'd0;
      gap_cnt    <= 4'd0;
      sweep_done <= 1'b0;
    end else begin
      cur        <= nxt_cur;
      sweep_done <= cmplt_w && last_smp && (cur == LAST_CHNL);
      if (nxt_state == START) chnnl <= nxt_cur;
      if (nxt_state == GAP && state != GAP)  gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) bank[i] <= 12'h000;
    end else if (cmplt_w && last_smp) begin
      bank[cur] <= wr_val;
    end
  end

endmodule

// File: tb/tb_a2d_chnl_sequencer.sv
// Bench for a2d_chnl_sequencer: behavioural A2D_intf models plus bank/channel scoreboards.
// Two instances: 8 channels with SETTLE=2, and 3 channels with SETTLE=0.
module tb_a2d_chnl_sequencer;

  localparam int LAT  = 20;
  localparam int SET  = 2;
  localparam int LAT3 = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en = 1'b0, cnv_cmplt = 1'b0, strt_cnv, sweep_done;
  logic [2:0]  chnnl, rd_chnl = 3'd0;
  logic [11:0] res = 12'h000, rd_data;
  logic        en3 = 1'b0, cnv_cmplt3 = 1'b0, strt_cnv3, sweep_done3;
  logic [2:0]  chnnl3, rd_chnl3 = 3'd0;
  logic [11:0] res3 = 12'h000, rd_data3;

  a2d_chnl_sequencer #(.NUM_CHNL(8), .SETTLE(SET)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .rd_chnl(rd_chnl), .rd_data(rd_data),
    .sweep_done(sweep_done));

  a2d_chnl_sequencer #(.NUM_CHNL(3), .SETTLE(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .strt_cnv(strt_cnv3), .chnnl(chnnl3),
    .cnv_cmplt(cnv_cmplt3), .res(res3), .rd_chnl(rd_chnl3), .rd_data(rd_data3),
    .sweep_done(sweep_done3));

  initial forever #10 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  typedef struct {int ch; logic [11:0] val;} sb_t;

  sb_t         sb[$];
  int          exp_ch[$], exp_ch3[$];
  logic [11:0] avg_q[$];
  logic [11:0] ref_bank [0:7];
  logic [11:0] res_ofs = 12'h000;
  int cyc = 0, n_strt = 0, n_cmplt = 0, n_sweep = 0, busy_cnt = 0, last_cmplt = -1;
  int n_strt3 = 0, n_cmplt3 = 0, n_sweep3 = 0, busy_cnt3 = 0, last_cmplt3 = -1;
  int spur_idle_req = 0, spur_idle_done = 0, spur_gap_req = 0, spur_gap_done = 0;
  bit busy = 0, sweep_exp = 0, gap_arm = 0, busy3 = 0, sweep_exp3 = 0;
  logic [2:0]  cur_ch = 3'd0, cur_ch3 = 3'd0;
  logic [11:0] r_m, r_m3;
  int e_ch, e_ch3;

  // A2D_intf model for the 8-channel instance, with injectable stray cnv_cmplt pulses.
  initial forever begin
    @(negedge clk);
    cyc++;
    cnv_cmplt = 1'b0;
    chk("sweep_done", 32'(sweep_done), 32'(sweep_exp));
    sweep_exp = 1'b0;
    if (sweep_done) n_sweep++;
    if (strt_cnv) begin
      n_strt++;
      if (exp_ch.size() > 0) e_ch = exp_ch.pop_front();
      else e_ch = 8;
      chk("chnnl_seq", 32'(chnnl), 32'(e_ch));
      if (last_cmplt >= 0) chk("settle_gap", 32'(cyc - last_cmplt), 32'(SET + 1));
      busy = 1'b1; busy_cnt = LAT; cur_ch = chnnl;
    end else if (busy) begin
      chk("chnnl_hold", 32'(chnnl), 32'(cur_ch));
      busy_cnt--;
      if (busy_cnt == 0) begin
        busy = 1'b0; n_cmplt++;
        if (avg_q.size() > 0) r_m = avg_q.pop_front();
        else r_m = {1'b0, cur_ch, 8'h05} + res_ofs;
        cnv_cmplt = 1'b1; res = r_m;
        sb.push_back('{int'(cur_ch), r_m});
        sweep_exp = (cur_ch == 3'd7);
        last_cmplt = en ? cyc : -1;
        gap_arm = (spur_gap_req != spur_gap_done);
      end
    end else if (gap_arm) begin
      gap_arm = 1'b0; spur_gap_done++;
      cnv_cmplt = 1'b1; res = 12'hFFF;
    end else if (spur_idle_req != spur_idle_done) begin
      spur_idle_done++;
      cnv_cmplt = 1'b1; res = 12'hFFF;
    end
  end

  initial forever begin
    @(negedge clk);
    cnv_cmplt3 = 1'b0;
    chk("sweep_done3", 32'(sweep_done3), 32'(sweep_exp3));
    sweep_exp3 = 1'b0;
    if (sweep_done3) n_sweep3++;
    if (strt_cnv3) begin
      n_strt3++;
      if (exp_ch3.size() > 0) e_ch3 = exp_ch3.pop_front();
      else e_ch3 = 8;
      chk("chnnl_seq3", 32'(chnnl3), 32'(e_ch3));
      if (last_cmplt3 >= 0) chk("settle_gap3", 32'(cyc - last_cmplt3), 32'(1));
      busy3 = 1'b1; busy_cnt3 = LAT3; cur_ch3 = chnnl3;
    end else if (busy3) begin
      chk("chnnl_hold3", 32'(chnnl3), 32'(cur_ch3));
      busy_cnt3--;
      if (busy_cnt3 == 0) begin
        busy3 = 1'b0; n_cmplt3++;
        r_m3 = {1'b0, cur_ch3, 8'h05};
        cnv_cmplt3 = 1'b1; res3 = r_m3;
        sweep_exp3 = (cur_ch3 == 3'd2);
        last_cmplt3 = en3 ? cyc : -1;
      end
    end
  end

  task automatic chk_bank();
    sb_t e;
    @(posedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ref_bank[e.ch] = e.val;
    end
    for (int i = 0; i < 8; i++) begin
      rd_chnl = 3'(i); #1;
      chk($sformatf("bank%0d", i), 32'(rd_data), 32'(ref_bank[i]));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ref_bank[i] = 12'h000;
    repeat (3) @(posedge clk); #1;
    chk("rst_strt", 32'(strt_cnv), 32'(0));
    chk("rst_chnnl", 32'(chnnl), 32'(0));
    chk("rst_sweep", 32'(sweep_done), 32'(0));
    #1 rst_n = 1'b1;
    chk_bank();
    repeat (10) @(posedge clk);
    chk("idle_no_strt", 32'(n_strt), 32'(0));

`ifdef A2D_AVG_EN
    avg_q.push_back(12'h100); avg_q.push_back(12'h101);
    avg_q.push_back(12'h102); avg_q.push_back(12'h104);
    for (int i = 0; i < 4; i++) avg_q.push_back(12'hFFF);
    avg_q.push_back(12'h123);
    for (int i = 0; i < 4; i++) exp_ch.push_back(0);
    for (int i = 0; i < 4; i++) exp_ch.push_back(1);
    exp_ch.push_back(2);
    #2 en = 1'b1;
    for (int i = 0; i < 3000 && n_strt < 9; i++) @(posedge clk);
    chk("avg_strt", 32'(n_strt), 32'(9));
    #2 en = 1'b0;
    for (int i = 0; i < 100 && n_cmplt < 9; i++) @(posedge clk);
    chk("avg_cmplt", 32'(n_cmplt), 32'(9));
    repeat (30) @(posedge clk); #1;
    chk("avg_no_strt", 32'(n_strt), 32'(9));
    chk("avg_sweep", 32'(n_sweep), 32'(0));
    rd_chnl = 3'd0; #1 chk("avg_bank0", 32'(rd_data), 32'(12'h101));
    rd_chnl = 3'd1; #1 chk("avg_bank1", 32'(rd_data), 32'(12'hFFF));
    rd_chnl = 3'd2; #1 chk("avg_bank2", 32'(rd_data), 32'(12'h000));
`else
    // Full sweep, then the second sweep is cut during ch4.
    for (int i = 0; i < 13; i++) exp_ch.push_back(i % 8);
    #2 en = 1'b1;
    for (int i = 0; i < 2000 && n_cmplt < 8; i++) @(posedge clk);
    chk("t2_cmplt", 32'(n_cmplt), 32'(8));
    res_ofs = 12'h0A0;
    chk_bank();
    rd_chnl = 3'd3; #1 chk("t2_bank3", 32'(rd_data), 32'(12'h305));
    @(posedge clk);
    chk("t2_sweep_cnt", 32'(n_sweep), 32'(1));

    for (int i = 0; i < 2000 && n_strt < 13; i++) @(posedge clk);
    chk("t3_strt", 32'(n_strt), 32'(13));
    repeat (3) @(posedge clk);
    #2 en = 1'b0;
    for (int i = 0; i < 100 && n_cmplt < 13; i++) @(posedge clk);
    chk("t3_cmplt", 32'(n_cmplt), 32'(13));
    repeat (30) @(posedge clk);
    chk("t3_no_strt", 32'(n_strt), 32'(13));
    chk_bank();
    rd_chnl = 3'd4; #1 chk("t3_bank4", 32'(rd_data), 32'(12'h4A5));

    // Stray cnv_cmplt while idle, then while in the settle gap.
    spur_idle_req = 1;
    repeat (5) @(posedge clk); #1;
    chk("t4_idle_spur", 32'(spur_idle_done), 32'(1));
    chk("t4_chnnl_idle", 32'(chnnl), 32'(4));
    chk("t4_no_strt", 32'(n_strt), 32'(13));
    chk_bank();
    spur_gap_req = 1;
    exp_ch.push_back(0); exp_ch.push_back(1);
    @(posedge clk); #2 en = 1'b1;
    for (int i = 0; i < 200 && n_strt < 15; i++) @(posedge clk);
    chk("t4_strt", 32'(n_strt), 32'(15));
    #2 en = 1'b0;
    for (int i = 0; i < 100 && n_cmplt < 15; i++) @(posedge clk);
    chk("t4_cmplt", 32'(n_cmplt), 32'(15));
    repeat (30) @(posedge clk);
    chk("t4_gap_spur", 32'(spur_gap_done), 32'(1));
    chk("t4_no_strt2", 32'(n_strt), 32'(15));
    chk_bank();

    // 3-channel instance with no settle gap.
    for (int i = 0; i < 7; i++) exp_ch3.push_back(i % 3);
    #2 en3 = 1'b1;
    for (int i = 0; i < 500 && n_strt3 < 7; i++) @(posedge clk);
    chk("t5_strt", 32'(n_strt3), 32'(7));
    #2 en3 = 1'b0;
    for (int i = 0; i < 100 && n_cmplt3 < 7; i++) @(posedge clk);
    chk("t5_cmplt", 32'(n_cmplt3), 32'(7));
    repeat (10) @(posedge clk); #1;
    chk("t5_no_strt", 32'(n_strt3), 32'(7));
    chk("t5_sweep_cnt", 32'(n_sweep3), 32'(2));
    rd_chnl3 = 3'd5; #1 chk("t5_rd_oob", 32'(rd_data3), 32'(12'h000));
    rd_chnl3 = 3'd2; #1 chk("t5_bank2", 32'(rd_data3), 32'(12'h205));
    rd_chnl3 = 3'd0; #1 chk("t5_bank0", 32'(rd_data3), 32'(12'h005));
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
